// File: rtl/sw_array_feeder.sv
// sw_array_feeder: source end of the Smith-Waterman PE chain.
// Loads the short read one base per PE, then streams reference bases into PE0 and drains.
`default_nettype none

module sw_array_feeder #(
    parameter int NUM_PE  = 6,
    parameter int WIDTH   = 10,
    parameter int V_BOUND = 0,
    parameter int F_BOUND = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        read_base,
    input  logic              read_valid,
    output logic              read_ready,
    input  logic [1:0]        ref_base,
    input  logic              ref_valid,
    input  logic              ref_last,
    output logic              ref_ready,
    output logic [1:0]        S_out,
    output logic [NUM_PE-1:0] store_S,
    output logic [1:0]        T_out,
    output logic              init_out,
    output logic [WIDTH-1:0]  V_out,
    output logic [WIDTH-1:0]  F_out,
    output logic              busy,
    output logic              done,
    output logic              err_underrun,
    output logic [CNT_W-1:0]  ref_count
);

    localparam int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int DCNT_W = $clog2(NUM_PE + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_PE - 1);
    localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(NUM_PE);
    localparam logic [NUM_PE-1:0] ONE_HOT0   = NUM_PE'(1);

    logic [1:0]        state, state_nx;
    logic [IDX_W-1:0]  load_idx, load_idx_nx;
    logic [DCNT_W-1:0] drain_cnt, drain_cnt_nx;

    logic              read_ready_nx, ref_ready_nx, init_nx, busy_nx, done_nx, err_nx;
    logic [1:0]        S_nx, T_nx;
    logic [NUM_PE-1:0] store_nx;
    logic [CNT_W-1:0]  ref_count_nx;

    logic read_acc, ref_acc;

    // The ready flags are only ever high in their own state, so they qualify the handshakes.
    assign read_acc = read_valid && read_ready;
    assign ref_acc  = ref_valid && ref_ready;

    assign V_out = WIDTH'(V_BOUND);
    assign F_out = WIDTH'(F_BOUND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_LOAD;
            ST_LOAD:   if (read_acc && (load_idx == LAST_IDX)) state_nx = ST_STREAM;
            // PEs cannot stall: a missing base ends the stream just like ref_last.
            ST_STREAM: if (!ref_valid || ref_last) state_nx = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt == '0) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        load_idx_nx   = load_idx;
        drain_cnt_nx  = drain_cnt;
        S_nx          = S_out;
        T_nx          = T_out;
        store_nx      = '0;
        init_nx       = 1'b0;
        done_nx       = 1'b0;
        err_nx        = err_underrun;
        ref_count_nx  = ref_count;
        read_ready_nx = (state_nx == ST_LOAD);
        ref_ready_nx  = (state_nx == ST_STREAM);
        busy_nx       = (state_nx != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    err_nx       = 1'b0;
                    ref_count_nx = '0;
                    load_idx_nx  = '0;
                end
            end
            ST_LOAD: begin
                if (read_acc) begin
                    S_nx        = read_base;
                    store_nx    = ONE_HOT0 << load_idx;
                    load_idx_nx = load_idx + 1'b1;
                end
            end
            ST_STREAM: begin
                if (ref_acc) begin
                    T_nx    = ref_base;
                    init_nx = 1'b1;
                    if (ref_count != {CNT_W{1'b1}}) ref_count_nx = ref_count + 1'b1;
                    if (ref_last) drain_cnt_nx = DRAIN_INIT;
                end else begin
                    err_nx       = 1'b1;
                    drain_cnt_nx = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    done_nx = 1'b1;
                end else begin
                    drain_cnt_nx = drain_cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_idx     <= '0;
            drain_cnt    <= '0;
            S_out        <= '0;
            T_out        <= '0;
            store_S      <= '0;
            init_out     <= 1'b0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
            ref_count    <= '0;
            read_ready   <= 1'b0;
            ref_ready    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            load_idx     <= load_idx_nx;
            drain_cnt    <= drain_cnt_nx;
            S_out        <= S_nx;
            T_out        <= T_nx;
            store_S      <= store_nx;
            init_out     <= init_nx;
            done         <= done_nx;
            err_underrun <= err_nx;
            ref_count    <= ref_count_nx;
            read_ready   <= read_ready_nx;
            ref_ready    <= ref_ready_nx;
            busy         <= busy_nx;
        end
    end

endmodule

`default_nettype wire

// File: doc/sw_array_feeder.md
Name: sw_array_feeder

Overview:
- Source end of the Smith-Waterman systolic array interface; drives PE0's V_in/F_in/T_in/init_in and every PE's S_in/store_S.
- Load phase: writes a NUM_PE-base short read into the PE chain, one base per PE, using a one-hot store strobe.
- Stream phase: pushes reference bases into PE0 with init asserted, then drains the array before it signals done.

Parameters:
- NUM_PE, 6, number of PEs in the chain and short-read length in bases.
- WIDTH, 10, score width; must match the PE score width.
- V_BOUND, 0, boundary V driven into PE0.
- F_BOUND, 0, boundary F driven into PE0.
- CNT_W, 16, width of the reference base counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins load; ignored unless IDLE.
- read_base  in  2  short-read base (00 A, 01 C, 10 G, 11 T).
- read_valid  in  1  read_base valid.
- read_ready  out  1  feeder accepts read_base.
- ref_base  in  2  reference base.
- ref_valid  in  1  ref_base valid.
- ref_last  in  1  marks the final reference base; qualified by ref_valid.
- ref_ready  out  1  feeder accepts ref_base.
- S_out  out  2  to all PEs' S_in.
- store_S  out  NUM_PE  one-hot store strobe; bit i goes to PE i.
- T_out  out  2  to PE0 T_in.
- init_out  out  1  to PE0 init_in.
- V_out  out  WIDTH  to PE0 V_in; constant V_BOUND.
- F_out  out  WIDTH  to PE0 F_in; constant F_BOUND.
- busy  out  1  high in LOAD, STREAM and DRAIN.
- done  out  1  one-cycle pulse at end of DRAIN.
- err_underrun  out  1  sticky stream-gap flag.
- ref_count  out  CNT_W  reference bases accepted this run; saturates at all-ones.

Behaviour:
- Reset (rst low, asynchronous): state IDLE.
  - Zero: S_out, store_S, T_out, init_out, read_ready, ref_ready, busy, done, err_underrun, ref_count.
  - V_out=V_BOUND, F_out=F_BOUND.
  - Reset mid-operation aborts immediately. No partial strobe survives.
- All outputs are registered. A handshake accepted at edge k appears on the outputs after edge k, i.e. one cycle latency.
- IDLE:
  - read_ready=0, ref_ready=0, init_out=0.
  - On start: clear err_underrun and ref_count, load_idx=0, go to LOAD.
- LOAD:
  - read_ready=1.
  - On each read_valid&&read_ready: S_out<=read_base and store_S<=(1<<load_idx) for exactly one cycle; load_idx++.
  - Cycles with no accept: store_S=0, S_out holds.
  - When the NUM_PE-th base is accepted, go to STREAM; read_ready drops on that same edge.
  - init_out=0 throughout LOAD.
- STREAM:
  - ref_ready=1.
  - On accept: T_out<=ref_base, init_out<=1, ref_count++ (saturating).
  - If ref_last is accepted: go to DRAIN with drain_cnt=NUM_PE.
  - A cycle with ref_valid=0 is an underrun, because the PEs have no stall:
    - err_underrun<=1, init_out<=0.
    - Go to DRAIN with drain_cnt=NUM_PE.
    - No further reference bases are accepted.
  - ref_last is ignored without ref_valid.
- DRAIN:
  - ref_ready=0, init_out=0, T_out holds.
  - drain_cnt decrements each cycle; when it reaches 0, done<=1 for one cycle and go to IDLE.
  - Last accepted base at edge k gives done high after edge k+NUM_PE+1.
- busy=1 in LOAD, STREAM and DRAIN, and drops together with the done pulse.
- start while busy is ignored. Simultaneous start and rst low: reset wins.
- store_S is never multi-hot. No PE index is strobed twice per run.
- ref_count, err_underrun and the last T_out remain readable in IDLE until the next start.

Test Plan:
- Reset: assert rst low mid-cycle -> all outputs reset asynchronously before the next edge; V_out=0, F_out=0, busy=0.
- Load: start, then read bases 00,01,00,01,11,00 on consecutive cycles with read_valid=1 -> store_S=000001, 000010, 000100, 001000, 010000, 100000 on six consecutive cycles, with S_out matching each base; init_out=0 throughout.
- Load with gaps: read_valid toggles 1,0,1,1,0,... -> store_S is zero on gap cycles, and each bit is strobed exactly once in order.
- Stream: reference 00,01,00,10,00,01,11,00 contiguous, ref_last on the 8th base:
  - T_out follows one cycle later; init_out is high for exactly 8 cycles.
  - ref_count=8.
  - done pulses 7 cycles after the last accept; err_underrun=0.
- Underrun: ref_valid drops after 3 bases ->
  - err_underrun=1, init_out=0 from the next edge.
  - ref_count=3.
  - done pulses 7 cycles after the gap.
  - The next start clears err_underrun.
- Illegal start and reset: start pulses during STREAM -> no effect. Then rst low during DRAIN -> done never pulses and the state returns to IDLE; a fresh start loads normally.
